// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the command-frame receive path and the command processor.
package cmd_frame_pkg;

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_DATA = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    localparam int unsigned CHK_W = 8;

    // Opcodes understood by the flight-control command processor
    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_ARM      = 8'h01;
    localparam logic [7:0] OP_DISARM   = 8'h02;
    localparam logic [7:0] OP_SET_RATE = 8'h05;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, expire_c fires on the cycle
// the count would reach TIMEOUT_CYCLES. A clear in the expiry cycle suppresses it.
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || !en || !ENABLED) begin
            cnt_q <= '0;
        end else if (cnt_q != SAT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_c = ENABLED && en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/cmd_frame_rx.sv
// Assembles opcode + payload (+ optional checksum) from the UART byte stream and presents
// the last good frame as registered cmd/data with a cmd_rdy level.
module cmd_frame_rx
    import cmd_frame_pkg::*;
#(
    parameter int unsigned DATA_BYTES     = 2,
    parameter int unsigned MSB_FIRST      = 1,
    parameter int unsigned CHK_EN         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_vld,
    input  logic                    clr_cmd_rdy,
    output logic [7:0]              cmd,
    output logic [8*DATA_BYTES-1:0] data,
    output logic                    cmd_rdy,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    chk_err
);

    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    state_t             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [DW-1:0]      pay_q, pay_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   lane_c;
    logic [CHK_W-1:0]   sum_q, sum_d;
    logic [7:0]         cmd_d;
    logic [DW-1:0]      data_d;
    logic               cmd_rdy_d, frame_err_d, chk_err_d, busy_d;
    logic               last_c, timeout_c, chk_ok_c, commit_c;

    assign last_c   = (idx_q == IDX_W'(DATA_BYTES - 1));
    assign lane_c   = (MSB_FIRST != 0) ? IDX_W'(DATA_BYTES - 1) - idx_q : idx_q;
    assign chk_ok_c = (CHK_W'(sum_q + rx_byte) == '0);

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (rx_vld),
        .en       (busy),
        .expire_c (timeout_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; expiry is already masked by a same-cycle byte
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = ST_CMD;
        end else if (rx_vld) begin
            case (state_q)
                ST_CMD:  state_d = ST_DATA;
                ST_DATA: if (last_c) state_d = (CHK_EN != 0) ? ST_CHK : ST_CMD;
                ST_CHK:  state_d = ST_CMD;
                default: state_d = ST_CMD;
            endcase
        end
    end

    // Shadow capture, checksum and commit; a commit's set of cmd_rdy overrides the host clear
    always_comb begin
        op_d        = op_q;
        pay_d       = pay_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cmd_d       = cmd;
        data_d      = data;
        cmd_rdy_d   = cmd_rdy & ~clr_cmd_rdy;
        frame_err_d = 1'b0;
        chk_err_d   = 1'b0;
        commit_c    = 1'b0;
        busy_d      = (state_d != ST_CMD);

        if (timeout_c) begin
            op_d        = '0;
            pay_d       = '0;
            idx_d       = '0;
            sum_d       = '0;
            frame_err_d = 1'b1;
        end else if (rx_vld) begin
            case (state_q)
                ST_CMD: begin
                    op_d      = rx_byte;
                    pay_d     = '0;
                    idx_d     = '0;
                    sum_d     = rx_byte;
                    cmd_rdy_d = 1'b0;
                end
                ST_DATA: begin
                    for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                        if (lane_c == IDX_W'(b)) pay_d[8*b +: 8] = rx_byte;
                    end
                    idx_d    = idx_q + 1'b1;
                    sum_d    = sum_q + rx_byte;
                    commit_c = last_c && (CHK_EN == 0);
                end
                ST_CHK: begin
                    if (chk_ok_c) commit_c  = 1'b1;
                    else          chk_err_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (commit_c) begin
            cmd_d     = op_q;
            data_d    = pay_d;
            cmd_rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            pay_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            cmd       <= '0;
            data      <= '0;
            cmd_rdy   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            op_q      <= op_d;
            pay_q     <= pay_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            cmd       <= cmd_d;
            data      <= data_d;
            cmd_rdy   <= cmd_rdy_d;
            busy      <= busy_d;
            frame_err <= frame_err_d;
            chk_err   <= chk_err_d;
        end
    end

endmodule
